// File: rtl/quaternion_conj_stream.sv
// ---------------------------------------------------------------------------
// quaternion_conj_stream
//
// Streaming quaternion sign transform with an output FIFO. Each accepted
// beat is transformed according to its mode and then buffered. The head of
// the buffer is always presented on t0..t3.
//
//   mode 00 : pass            t = q
//   mode 01 : conjugate       t0 = q0, t1..t3 = sign-flipped q1..q3
//   mode 10 : negate          t0..t3 = sign-flipped q0..q3
//   mode 11 : scalar negate   t0 = sign-flipped q0, t1..t3 = q1..q3
//
// Sign flipping inverts only bit W-1. Zeros, infinities and NaNs keep every
// other bit.
//
// Ports:
//   clk        : clock; all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : input quaternion present
//   in_ready   : block accepts the input this cycle (level != DEPTH)
//   q0..q3     : input scalar (q0) and vector (q1..q3) parts, W bits each
//   mode       : per-beat operation, sampled with the input
//   out_valid  : result present (level != 0)
//   out_ready  : consumer accepts the result
//   t0..t3     : head-of-buffer result components
//   level      : buffer occupancy, 0..DEPTH
//   beat_count : 32-bit count of pops, wrapping (only with QCONJ_STATS_EN)
//
// Optional feature macro: QCONJ_STATS_EN adds the beat_count output.
// ---------------------------------------------------------------------------
module quaternion_conj_stream #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               q0,
  input  logic [W-1:0]               q1,
  input  logic [W-1:0]               q2,
  input  logic [W-1:0]               q3,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               t0,
  output logic [W-1:0]               t1,
  output logic [W-1:0]               t2,
  output logic [W-1:0]               t3,
  output logic [$clog2(DEPTH):0]     level
`ifdef QCONJ_STATS_EN
  ,
  output logic [31:0]                beat_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 4 * W;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  // Invert only the sign bit; all other bits pass through untouched.
  function automatic logic [W-1:0] flip_sign(input logic [W-1:0] x);
    return {~x[W-1], x[W-2:0]};
  endfunction

  // Storage and control state
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head_q, head_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, out_valid_q;
  logic          push_s, pop_s;
  logic [EW-1:0] xform_s;

  // Handshakes use only registered flags, so out_ready never reaches in_ready.
  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;

  // Per-beat sign transform selected by mode.
  always_comb begin
    xform_s = {q0, q1, q2, q3};
    case (mode)
      2'b00:   xform_s = {q0, q1, q2, q3};
      2'b01:   xform_s = {q0, flip_sign(q1), flip_sign(q2), flip_sign(q3)};
      2'b10:   xform_s = {flip_sign(q0), flip_sign(q1), flip_sign(q2), flip_sign(q3)};
      2'b11:   xform_s = {flip_sign(q0), q1, q2, q3};
      default: xform_s = {q0, q1, q2, q3};
    endcase
  end

  // Next-state for pointers, occupancy and the registered head entry.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    head_d  = head_q;

    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end

    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // The new head is either already in storage or is the beat being
    // written this cycle (the buffer is, or is about to become, empty).
    if (level_d != LVL_ZERO) begin
      if (push_s && (level_q == {{(LW-1){1'b0}}, pop_s})) begin
        head_d = xform_s;
      end else begin
        head_d = mem_q[rptr_d];
      end
    end else begin
      head_d = head_q;
    end
  end

  // Control registers, head register and handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q      <= {PW{1'b0}};
      wptr_q      <= {PW{1'b0}};
      level_q     <= LVL_ZERO;
      head_q      <= {EW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      in_ready_q  <= (level_d != LVL_FULL);
      out_valid_q <= (level_d != LVL_ZERO);
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wptr_q] <= xform_s;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign t0        = head_q[4*W-1:3*W];
  assign t1        = head_q[3*W-1:2*W];
  assign t2        = head_q[2*W-1:W];
  assign t3        = head_q[W-1:0];

`ifdef QCONJ_STATS_EN
  logic [31:0] beat_count_q;

  // Count popped beats; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count_q <= 32'h0000_0000;
    end else if (pop_s) begin
      beat_count_q <= beat_count_q + 32'h0000_0001;
    end else begin
      beat_count_q <= beat_count_q;
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_quaternion_conj_stream.sv
module tb_quaternion_conj_stream;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  q0, q1, q2, q3;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  t0, t1, t2, t3;
  logic [LW-1:0] level;
`ifdef QCONJ_STATS_EN
  logic [31:0]   beat_count;
`endif

  int n_vec;
  int n_bad;

  quaternion_conj_stream #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .t0        (t0),
    .t1        (t1),
    .t2        (t2),
    .t3        (t3),
    .level     (level)
`ifdef QCONJ_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] q;
    logic [127:0] t;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [127:0] q);
    in_valid = v;
    mode     = m;
    {q0, q1, q2, q3} = q;
  endtask

  function automatic logic [127:0] beat(input int k);
    return {32'(k), 32'(k) + 32'h100, 32'(k) + 32'h200, 32'(k) + 32'h300};
  endfunction

  logic [127:0] sb [$];
  logic [127:0] tq;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 128'h0);

    vecs[0] = '{2'b01, {32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000},
                       {32'h3F800000, 32'hC0000000, 32'h40400000, 32'h80000000}};
    vecs[1] = '{2'b10, {32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000},
                       {32'hBF800000, 32'hC0000000, 32'h40400000, 32'h80000000}};
    vecs[2] = '{2'b11, {32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000},
                       {32'hBF800000, 32'h40000000, 32'hC0400000, 32'h00000000}};
    vecs[3] = '{2'b00, {32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000},
                       {32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000}};
    vecs[4] = '{2'b10, {32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h80000000},
                       {32'hFF800000, 32'h7F800000, 32'hFFC00001, 32'h00000000}};
    vecs[5] = '{2'b01, {32'h12345678, 32'h9ABCDEF0, 32'h00000001, 32'hFFFFFFFF},
                       {32'h12345678, 32'h1ABCDEF0, 32'h80000001, 32'h7FFFFFFF}};
    vecs[6] = '{2'b11, {32'h12345678, 32'h9ABCDEF0, 32'h00000001, 32'hFFFFFFFF},
                       {32'h92345678, 32'h9ABCDEF0, 32'h00000001, 32'hFFFFFFFF}};
    vecs[7] = '{2'b00, {32'hDEADBEEF, 32'h00000000, 32'h80000000, 32'h7FFFFFFF},
                       {32'hDEADBEEF, 32'h00000000, 32'h80000000, 32'h7FFFFFFF}};

    // Reset state
    @(negedge clk);
    tick();
    check("reset_level", 128'(level), 128'd0);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_t", {t0, t1, t2, t3}, 128'h0);
    rst_n = 1'b1;
    tick();

    // Push into empty: result must not appear before the edge
    drive(1'b1, vecs[0].mode, vecs[0].q);
    #1;
    check("no_comb_path_out_valid", 128'(out_valid), 128'd0);
    check("no_comb_path_t", {t0, t1, t2, t3}, 128'h0);

    // Table: one beat per cycle, out_ready high, level settles at 1
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].q);
      tick();
      check($sformatf("vec%0d_t", i), {t0, t1, t2, t3}, vecs[i].t);
      check($sformatf("vec%0d_valid_level", i), {out_valid, 127'(level)}, {1'b1, 127'd1});
    end
    drive(1'b0, 2'b00, 128'h0);
    tick();
    check("drain_level", 128'(level), 128'd0);
    check("drain_out_valid", 128'(out_valid), 128'd0);

    // Fill to DEPTH with out_ready low, hold output stable, refuse 5th beat
    out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      drive(1'b1, 2'b00, beat(k));
      tick();
      check($sformatf("fill%0d_head_stable", k), {t0, t1, t2, t3}, beat(1));
    end
    check("full_level", 128'(level), 128'(DEPTH));
    check("full_in_ready", 128'(in_ready), 128'd0);
    drive(1'b1, 2'b00, beat(99));
    tick();
    check("full_refuse_level", 128'(level), 128'(DEPTH));
    drive(1'b0, 2'b00, 128'h0);
    out_ready = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      check($sformatf("full_pop%0d_t", k), {t0, t1, t2, t3}, beat(k));
      tick();
      if (k == 1) check("in_ready_after_first_pop", 128'(in_ready), 128'd1);
    end
    check("full_drain_level", 128'(level), 128'd0);

    // Level 2, simultaneous push/pop for 10 cycles across pointer wrap
    out_ready = 1'b0;
    sb.delete();
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 2'b00, beat(k));
      sb.push_back(beat(k));
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 2'b00, beat(3 + c));
      sb.push_back(beat(3 + c));
      tq = sb.pop_front();
      tick();
      check($sformatf("steady%0d_level", c), 128'(level), 128'd2);
      check($sformatf("steady%0d_t", c), {t0, t1, t2, t3}, sb[0]);
    end

    // Bring level to 3, then reset with in_valid high
    drive(1'b1, 2'b10, beat(50));
    out_ready = 1'b0;
    tick();
    check("pre_reset_level", 128'(level), 128'd3);
    rst_n = 1'b0;
    drive(1'b1, 2'b00, beat(77));
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 128'h0);
    check("mid_reset_level", 128'(level), 128'd0);
    check("mid_reset_out_valid", 128'(out_valid), 128'd0);
    check("mid_reset_t", {t0, t1, t2, t3}, 128'h0);
    tick();
    check("post_reset_level", 128'(level), 128'd0);

`ifdef QCONJ_STATS_EN
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 2'b00, beat(k));
      tick();
    end
    drive(1'b0, 2'b00, 128'h0);
    force dut.beat_count_q = 32'hFFFFFFFE;
    #1;
    release dut.beat_count_q;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("beat_count_wrap", 128'(beat_count), 128'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
